// File: rtl/alu_op_driver.sv
// Initiator for a combinational 4-bit ALU: accepts single commands or opcode sweeps,
// drives registered operands, waits SETTLE cycles, and returns the captured result.
//
// state | meaning
// IDLE  | waiting for a command or sweep request
// DRIVE | operands on the ALU, settle counter running
// RESP  | result held on the response port until accepted
module alu_op_driver #(
  parameter int WIDTH   = 4,
  parameter int SEL_W   = 3,
  parameter int SETTLE  = 1,
  parameter int NUM_OPS = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [SEL_W-1:0] cmd_sel,
  input  logic             sweep_start,
  input  logic [WIDTH-1:0] sweep_a,
  input  logic [WIDTH-1:0] sweep_b,
  output logic             busy,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [SEL_W-1:0] alu_sel,
  input  logic [WIDTH-1:0] alu_y,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_y,
  output logic [SEL_W-1:0] rsp_sel,
  output logic             rsp_last,
  output logic [7:0]       op_count
);

  localparam int CNT_W = $clog2(SETTLE + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE - 1);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_OPS - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

  state_t state, state_nxt;
  logic sweep_mode;
  logic [CNT_W-1:0] cnt;
  logic accept_sweep, accept_cmd, capture, rsp_hs, sweep_more;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    accept_sweep = (state == IDLE) & sweep_start;
    accept_cmd   = (state == IDLE) & ~sweep_start & cmd_valid;
    capture      = (state == DRIVE) & (cnt == '0);
    rsp_hs       = (state == RESP) & rsp_valid & rsp_ready;
    sweep_more   = sweep_mode & (alu_sel < LAST_SEL);
    state_nxt    = state;
    case (state)
      IDLE:    if (accept_sweep | accept_cmd) state_nxt = DRIVE;
      DRIVE:   if (capture) state_nxt = RESP;
      RESP:    if (rsp_hs) state_nxt = sweep_more ? DRIVE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // rst_n gating keeps ready low while reset is asserted even though state is IDLE
  assign cmd_ready = rst_n & (state == IDLE) & ~sweep_start;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweep_mode <= 1'b0;
      cnt        <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      rsp_valid  <= 1'b0;
      rsp_y      <= '0;
      rsp_sel    <= '0;
      rsp_last   <= 1'b0;
      op_count   <= '0;
    end else begin
      if (accept_sweep) begin
        alu_a      <= sweep_a;
        alu_b      <= sweep_b;
        alu_sel    <= '0;
        sweep_mode <= 1'b1;
        cnt        <= CNT_INIT;
      end else if (accept_cmd) begin
        alu_a      <= cmd_a;
        alu_b      <= cmd_b;
        alu_sel    <= cmd_sel;
        sweep_mode <= 1'b0;
        cnt        <= CNT_INIT;
      end
      if ((state == DRIVE) && (cnt != '0)) cnt <= cnt - 1'b1;
      if (capture) begin
        rsp_y     <= alu_y;
        rsp_sel   <= alu_sel;
        rsp_valid <= 1'b1;
        rsp_last  <= ~sweep_mode | (alu_sel == LAST_SEL);
      end
      if (rsp_hs) begin
        rsp_valid <= 1'b0;
        op_count  <= op_count + 8'd1;
        if (sweep_more) begin
          alu_sel <= alu_sel + 1'b1;
          cnt     <= CNT_INIT;
        end else begin
          sweep_mode <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_op_driver.sv
// Bench for alu_op_driver: job-queue reference model checked every cycle, directed
// scenarios with hand-computed values, and a randomized traffic phase.
module tb_alu_op_driver;

  localparam int SETTLE  = 1;
  localparam int NUM_OPS = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0, sweep_start = 1'b0, rsp_ready = 1'b1;
  logic [3:0] cmd_a = '0, cmd_b = '0, sweep_a = '0, sweep_b = '0;
  logic [2:0] cmd_sel = '0;
  logic       cmd_ready, busy, rsp_valid, rsp_last;
  logic [3:0] alu_a, alu_b, alu_y, rsp_y;
  logic [2:0] alu_sel, rsp_sel;
  logic [7:0] op_count;

  int n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  function automatic logic [3:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                        input logic [2:0] s);
    case (s)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      default: return 4'd0;
    endcase
  endfunction

  assign alu_y = alu_fn(alu_a, alu_b, alu_sel);

  alu_op_driver #(.WIDTH(4), .SEL_W(3), .SETTLE(SETTLE), .NUM_OPS(NUM_OPS)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel),
    .sweep_start(sweep_start), .sweep_a(sweep_a), .sweep_b(sweep_b),
    .busy(busy), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_y(alu_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y),
    .rsp_sel(rsp_sel), .rsp_last(rsp_last), .op_count(op_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pending operations for the current job.
  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] sel;
    logic       last;
  } op_t;

  op_t        job[$];
  int         wait_m = 0;
  int         acc_cnt = 0;
  logic       rv_m = 0, rl_m = 0;
  logic [3:0] ry_m = 0, aa_m = 0, ab_m = 0;
  logic [2:0] rs_m = 0, as_m = 0;
  logic [7:0] cnt_m = 0;

  always @(posedge clk or negedge rst_n) begin
    op_t o;
    if (!rst_n) begin
      job.delete();
      wait_m = 0; rv_m = 0; ry_m = 0; rs_m = 0; rl_m = 0;
      aa_m = 0; ab_m = 0; as_m = 0; cnt_m = 0;
    end else if (job.size() == 0) begin
      if (sweep_start) begin
        for (int s = 0; s < NUM_OPS; s++) begin
          o.a = sweep_a; o.b = sweep_b; o.sel = 3'(s); o.last = (s == NUM_OPS - 1);
          job.push_back(o);
        end
      end else if (cmd_valid) begin
        o.a = cmd_a; o.b = cmd_b; o.sel = cmd_sel; o.last = 1'b1;
        job.push_back(o);
      end
      if (job.size() != 0) begin
        acc_cnt++;
        aa_m = job[0].a; ab_m = job[0].b; as_m = job[0].sel;
        wait_m = SETTLE;
      end
    end else if (wait_m > 0) begin
      wait_m--;
      if (wait_m == 0) begin
        rv_m = 1'b1;
        ry_m = alu_fn(job[0].a, job[0].b, job[0].sel);
        rs_m = job[0].sel;
        rl_m = job[0].last;
      end
    end else if (rsp_ready) begin
      rv_m = 1'b0;
      cnt_m++;
      void'(job.pop_front());
      if (job.size() != 0) begin
        as_m = job[0].sel;
        wait_m = SETTLE;
      end
    end
  end

  always @(negedge clk) begin
    chk("cmd_ready", cmd_ready, (job.size() == 0) && !sweep_start && rst_n);
    chk("busy", busy, job.size() != 0);
    chk("alu_a", alu_a, aa_m);
    chk("alu_b", alu_b, ab_m);
    chk("alu_sel", alu_sel, as_m);
    chk("rsp_valid", rsp_valid, rv_m);
    if (rv_m) begin
      chk("rsp_y", rsp_y, ry_m);
      chk("rsp_sel", rsp_sel, rs_m);
      chk("rsp_last", rsp_last, rl_m);
    end
    chk("op_count", op_count, cnt_m);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s);
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_sel = s;
    tick();
    cmd_valid = 1'b0;
    cmd_a = 4'($urandom); cmd_b = 4'($urandom); cmd_sel = 3'($urandom);
  endtask

  task automatic wait_idle(input bit rand_ready);
    for (int i = 0; i < 60; i++) begin
      if (job.size() == 0) return;
      if (rand_ready) rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    chk("wait_idle_timeout", 1, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] sweep_exp [5];
    int start_acc;
    sweep_exp[0] = 4'd8; sweep_exp[1] = 4'd2; sweep_exp[2] = 4'd1;
    sweep_exp[3] = 4'd7; sweep_exp[4] = 4'd6;

    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // single command
    send_cmd(4'd5, 4'd3, 3'd0);
    chk("t1_alu_a", alu_a, 5);
    chk("t1_alu_b", alu_b, 3);
    chk("t1_busy", busy, 1);
    chk("t1_valid_early", rsp_valid, 0);
    tick();
    chk("t1_valid", rsp_valid, 1);
    chk("t1_y", rsp_y, 8);
    chk("t1_sel", rsp_sel, 0);
    chk("t1_last", rsp_last, 1);
    tick();
    chk("t1_count", op_count, 1);
    chk("t1_busy_fall", busy, 0);

    // full sweep
    sweep_a = 4'd5; sweep_b = 4'd3; sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_valid", rsp_valid, 1);
      chk("t2_y", rsp_y, sweep_exp[i]);
      chk("t2_sel", rsp_sel, i);
      chk("t2_last", rsp_last, i == 4);
      tick();
    end
    chk("t2_count", op_count, 6);
    chk("t2_idle", busy, 0);

    // backpressure
    rsp_ready = 1'b0;
    send_cmd(4'd15, 4'd1, 3'd0);
    tick();
    repeat (6) begin
      chk("t3_valid_hold", rsp_valid, 1);
      chk("t3_y_hold", rsp_y, 0);
      chk("t3_ready_low", cmd_ready, 0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk("t3_count", op_count, 7);
    chk("t3_valid_drop", rsp_valid, 0);
    tick();
    chk("t3_single_hs", op_count, 7);

    // sweep wins over a simultaneous command
    start_acc = acc_cnt;
    sweep_a = 4'd6; sweep_b = 4'd2; sweep_start = 1'b1;
    cmd_valid = 1'b1; cmd_a = 4'd9; cmd_b = 4'd4; cmd_sel = 3'd1;
    #1;
    chk("t4_ready_low", cmd_ready, 0);
    tick();
    sweep_start = 1'b0;
    for (int i = 0; i < 40 && acc_cnt < start_acc + 2; i++) tick();
    cmd_valid = 1'b0;
    wait_idle(0);
    chk("t4_alu_a", alu_a, 9);
    chk("t4_alu_sel", alu_sel, 1);
    chk("t4_count", op_count, 13);

    // async reset mid-sweep
    sweep_a = 4'd5; sweep_b = 4'd3; sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    repeat (6) tick();
    chk("t5_count_pre", op_count, 16);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_valid", rsp_valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_alu_a", alu_a, 0);
    chk("t5_alu_sel", alu_sel, 0);
    chk("t5_count", op_count, 0);
    chk("t5_ready", cmd_ready, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    send_cmd(4'd7, 4'd2, 3'd1);
    tick();
    chk("t5_y", rsp_y, 5);
    chk("t5_valid_after", rsp_valid, 1);
    tick();
    chk("t5_count_after", op_count, 1);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      cmd_valid   = $urandom_range(0, 1);
      cmd_a       = 4'($urandom); cmd_b = 4'($urandom); cmd_sel = 3'($urandom);
      sweep_start = ($urandom_range(0, 7) == 0);
      sweep_a     = 4'($urandom); sweep_b = 4'($urandom);
      rsp_ready   = ($urandom_range(0, 3) != 0);
      tick();
    end
    cmd_valid = 1'b0; sweep_start = 1'b0; rsp_ready = 1'b1;
    wait_idle(0);

    // op_count wrap
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 256; i++) begin
      send_cmd(4'($urandom), 4'($urandom), 3'($urandom));
      wait_idle(1);
      if (i == 254) chk("t6_count_255", op_count, 255);
    end
    chk("t6_wrap", op_count, 0);
    rsp_ready = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/alu_op_driver.md
Name: alu_op_driver

Overview:
Initiator side of the 4-bit ALU operand interface. It accepts single ALU commands, or a sweep request, through a valid/ready port, and drives registered a/b/sel onto a combinational ALU. It waits a programmable settle time, captures the ALU result, and returns it through a valid/ready response port. It sits between a control/sequencer block and the ALU, replacing free-running stimulus with a handshaked, cycle-exact operation stream.

Parameters:
WIDTH, 4, operand and result width
SEL_W, 3, opcode width
SETTLE, 1, cycles between driving operands and capturing alu_y (must be >= 1)
NUM_OPS, 5, number of opcodes issued by a sweep (sel 0 .. NUM_OPS-1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  single command present
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at a clk edge
cmd_a  in  WIDTH  operand a
cmd_b  in  WIDTH  operand b
cmd_sel  in  SEL_W  opcode
sweep_start  in  1  one-cycle request to sweep all opcodes
sweep_a  in  WIDTH  sweep operand a
sweep_b  in  WIDTH  sweep operand b
busy  out  1  state != IDLE
alu_a  out  WIDTH  registered operand a to the ALU
alu_b  out  WIDTH  registered operand b to the ALU
alu_sel  out  SEL_W  registered opcode to the ALU
alu_y  in  WIDTH  ALU result (combinational from alu_a/alu_b/alu_sel)
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts the result
rsp_y  out  WIDTH  captured result
rsp_sel  out  SEL_W  opcode that produced rsp_y
rsp_last  out  1  1 on a single-command response, and on the final sweep response
op_count  out  8  completed response handshakes, wraps 255 -> 0

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0: cmd_ready deasserts immediately, then rises with the IDLE rule after release. rsp_valid drops immediately. An in-flight op or sweep is abandoned, not resumed.
- States: IDLE, DRIVE, RESP. Internal flag sweep_mode, settle counter cnt.
- IDLE: cmd_ready = ~sweep_start (sweep has priority).
  - On sweep_start=1: load alu_a=sweep_a, alu_b=sweep_b, alu_sel=0, sweep_mode=1, cnt=SETTLE-1, go to DRIVE. cmd_valid is ignored that cycle.
  - Else, on cmd_valid: load alu_a/alu_b/alu_sel from the cmd_* inputs, sweep_mode=0, cnt=SETTLE-1, go to DRIVE.
- DRIVE: cmd_ready=0. If cnt != 0, decrement. If cnt == 0: rsp_y<=alu_y, rsp_sel<=alu_sel, rsp_valid<=1, rsp_last<=~sweep_mode | (alu_sel==NUM_OPS-1), go to RESP.
- Latency: command accepted at edge k -> rsp_valid high after edge k+SETTLE.
- RESP: rsp_y/rsp_sel/rsp_last are held stable while rsp_valid & ~rsp_ready. On rsp_valid & rsp_ready:
  - rsp_valid<=0; op_count+1 (mod 256).
  - If sweep_mode and alu_sel < NUM_OPS-1: alu_sel+1, cnt=SETTLE-1, go to DRIVE.
  - Otherwise go to IDLE, clear sweep_mode.
- Back-to-back rate: rsp_ready held 1 gives one result every SETTLE+1 cycles. A new command can be accepted the cycle after the response handshake, never in the same cycle.
- alu_a/alu_b/alu_sel hold their last driven values in IDLE; they are not cleared after an op.
- sweep_start outside IDLE is ignored, with no queueing. cmd_* inputs outside the acceptance edge are don't-care.
- busy = (state != IDLE).
- Widths: alu_sel increment stays in SEL_W. NUM_OPS <= 2^SEL_W, so the sweep never wraps sel.

Test Plan:
Bench ALU model: sel 000 a+b, 001 a-b, 010 a&b, 011 a|b, 100 a^b, all mod 16; SETTLE=1.
1. Reset release, then single cmd a=5, b=3, sel=000, rsp_ready=1 -> alu_a=5/alu_b=3 one edge after acceptance; rsp_valid rises at acceptance+1; rsp_y=8, rsp_sel=0, rsp_last=1, op_count=1, busy falls after the handshake.
2. sweep_start with sweep_a=5, sweep_b=3, rsp_ready=1 -> five responses rsp_y=8, 2, 1, 7, 6 with rsp_sel=0..4, each 2 cycles apart; rsp_last=1 only on sel=4; op_count +5.
3. Backpressure: single cmd a=15, b=1, sel=000 with rsp_ready=0 for 6 cycles -> rsp_valid stays 1 and rsp_y=0 (wrap) stays stable; cmd_ready=0 throughout; exactly one handshake when rsp_ready=1.
4. sweep_start and cmd_valid asserted together in IDLE -> cmd_ready=0 that cycle, sweep runs, and the command is accepted only after the sweep ends if still presented.
5. Assert rst_n=0 asynchronously mid-sweep (after the sel=2 response) -> rsp_valid, busy, alu_* and op_count go to 0 without a clock edge; after release, a new single cmd completes normally.
6. 256 single-command handshakes -> op_count wraps to 0.
